// File: rtl/cv32e40p_data_arbiter.sv
// rtl/cv32e40p_data_arbiter.sv - two-port data memory arbiter with in-order response routing
module cv32e40p_data_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_req_i,
  input  logic [31:0] p0_addr_i,
  input  logic        p0_we_i,
  input  logic [3:0]  p0_be_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,

  input  logic        p1_req_i,
  input  logic [31:0] p1_addr_i,
  input  logic        p1_we_i,
  input  logic [3:0]  p1_be_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        busy_o,
  output logic        err_o
);

  // Counter saturates at MAX_OUTSTANDING (at most 3), so two bits suffice.
  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  typedef enum logic {
    ARB,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [1:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic       err_q, err_d;

  // ID FIFO: bit 0 is the head, entries shift down on each pop.
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic [1:0]                 wr_ptr;

  logic sel;
  logic sel_req;
  logic can_issue;
  logic grant;
  logic rv_acc;

  // Pick the port to present: the latched one while held, else round-robin.
  always_comb begin
    sel = 1'b0;
    if (state_q == HOLD) begin
      sel = sel_q;
    end else if (p0_req_i && p1_req_i) begin
      sel = ~last_q;
    end else if (p1_req_i) begin
      sel = 1'b1;
    end
  end

  assign sel_req   = sel ? p1_req_i : p0_req_i;
  // A response in the same cycle frees a slot, so issuing at the limit is safe.
  assign can_issue = (cnt_q < MAX_CNT) | mem_rvalid_i;
  assign mem_req_o = ~rst & can_issue & sel_req;

  assign mem_addr_o  = sel ? p1_addr_i  : p0_addr_i;
  assign mem_we_o    = sel ? p1_we_i    : p0_we_i;
  assign mem_be_o    = sel ? p1_be_i    : p0_be_i;
  assign mem_wdata_o = sel ? p1_wdata_i : p0_wdata_i;

  assign grant    = mem_req_o & mem_gnt_i;
  assign p0_gnt_o = grant & ~sel;
  assign p1_gnt_o = grant & sel;

  // A response with nothing outstanding is spurious and must not touch state.
  assign rv_acc      = mem_rvalid_i & (cnt_q != 2'd0);
  assign p0_rvalid_o = rv_acc & ~id_q[0];
  assign p1_rvalid_o = rv_acc & id_q[0];
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;

  assign busy_o = (cnt_q != 2'd0);
  assign err_o  = err_q;

  // Arbitration FSM: hold the selected port stable while memory stalls the grant.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = HOLD;
          sel_d   = sel;
        end
      end
      HOLD: begin
        if (grant) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Outstanding count, round-robin history and the sticky protocol error.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    err_d  = err_q;
    if (grant && !rv_acc) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!grant && rv_acc) begin
      cnt_d = cnt_q - 2'd1;
    end
    if (grant) begin
      last_d = sel;
    end
    if (mem_rvalid_i && (cnt_q == 2'd0)) begin
      err_d = 1'b1;
    end
  end

  // ID FIFO update; a simultaneous pop moves the write slot down by one.
  always_comb begin
    id_d   = id_q;
    wr_ptr = rv_acc ? (cnt_q - 2'd1) : cnt_q;
    if (rv_acc) begin
      id_d = id_q >> 1;
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (grant && (i == int'(wr_ptr))) begin
        id_d[i] = sel;
      end
    end
  end

  // State registers with asynchronous reset; last_q resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      cnt_q   <= 2'd0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_data_arbiter.sv
// tb/tb_cv32e40p_data_arbiter.sv - randomized and directed checks against a queue-based arbiter model
module tb_cv32e40p_data_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req_i = 1'b0, p1_req_i = 1'b0;
  logic [31:0] p0_addr_i = '0, p1_addr_i = '0;
  logic        p0_we_i = 1'b0, p1_we_i = 1'b0;
  logic [3:0]  p0_be_i = '0, p1_be_i = '0;
  logic [31:0] p0_wdata_i = '0, p1_wdata_i = '0;
  logic        p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
  logic [31:0] p0_rdata_o, p1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o, err_o;

  always #5 clk = ~clk;

  cv32e40p_data_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
    .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
    .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester state: each port holds its request until granted.
  bit          pend[2];
  logic [31:0] r_addr[2];
  logic        r_we[2];
  logic [3:0]  r_be[2];
  logic [31:0] r_wdata[2];

  // Reference model: FIFO of granted port IDs, tie-break history, hold, sticky error.
  int m_q[$];
  bit m_last;
  bit m_hold;
  int m_hold_port;
  bit m_err;

  // DUT observations of the most recent step, plus logs of grants and responses.
  logic        obs_req, obs_p0_gnt, obs_p1_gnt, obs_p0_rv, obs_p1_rv, obs_busy, obs_err;
  logic [31:0] obs_addr, obs_p0_rdata, obs_p1_rdata;
  int          gnt_log[$];
  int          rv_log[$];
  logic [31:0] rvd_log[$];

  task automatic new_req(input int p, input logic [31:0] a);
    pend[p]    = 1'b1;
    r_addr[p]  = a;
    r_we[p]    = 1'($urandom);
    r_be[p]    = 4'($urandom);
    r_wdata[p] = $urandom;
  endtask

  task automatic clear_reqs();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    gnt_log.delete();
    rv_log.delete();
    rvd_log.delete();
  endtask

  task automatic drive_ports();
    p0_req_i = pend[0]; p0_addr_i = r_addr[0]; p0_we_i = r_we[0]; p0_be_i = r_be[0]; p0_wdata_i = r_wdata[0];
    p1_req_i = pend[1]; p1_addr_i = r_addr[1]; p1_we_i = r_we[1]; p1_be_i = r_be[1]; p1_wdata_i = r_wdata[1];
  endtask

  // One clock cycle: drive at the falling edge, check mid-low phase, advance the model, wait for the next falling edge.
  task automatic step(input bit g, input bit rv, input logic [31:0] rd);
    bit can, ereq, egnt, eacc;
    int sel, head;
    drive_ports();
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    #2;
    can = (m_q.size() < MAXO) || rv;
    sel = -1;
    if (m_hold) sel = m_hold_port;
    else if (pend[0] && pend[1]) sel = m_last ? 0 : 1;
    else if (pend[0]) sel = 0;
    else if (pend[1]) sel = 1;
    ereq = can && (sel >= 0) && pend[sel];
    egnt = ereq && g;
    eacc = rv && (m_q.size() > 0);
    head = eacc ? m_q[0] : -1;

    obs_req = mem_req_o; obs_addr = mem_addr_o;
    obs_p0_gnt = p0_gnt_o; obs_p1_gnt = p1_gnt_o;
    obs_p0_rv = p0_rvalid_o; obs_p1_rv = p1_rvalid_o;
    obs_p0_rdata = p0_rdata_o; obs_p1_rdata = p1_rdata_o;
    obs_busy = busy_o; obs_err = err_o;

    check_eq("mem_req", 32'(mem_req_o), 32'(ereq));
    if (ereq) begin
      check_eq("mem_addr", mem_addr_o, r_addr[sel]);
      check_eq("mem_we", 32'(mem_we_o), 32'(r_we[sel]));
      check_eq("mem_be", 32'(mem_be_o), 32'(r_be[sel]));
      check_eq("mem_wdata", mem_wdata_o, r_wdata[sel]);
    end
    check_eq("p0_gnt", 32'(p0_gnt_o), 32'(egnt && sel == 0));
    check_eq("p1_gnt", 32'(p1_gnt_o), 32'(egnt && sel == 1));
    check_eq("p0_rvalid", 32'(p0_rvalid_o), 32'(eacc && head == 0));
    check_eq("p1_rvalid", 32'(p1_rvalid_o), 32'(eacc && head == 1));
    check_eq("p0_rdata", p0_rdata_o, rd);
    check_eq("p1_rdata", p1_rdata_o, rd);
    check_eq("busy", 32'(busy_o), 32'(m_q.size() != 0));
    check_eq("err", 32'(err_o), 32'(m_err));

    if (p0_gnt_o) gnt_log.push_back(0);
    if (p1_gnt_o) gnt_log.push_back(1);
    if (p0_rvalid_o) begin rv_log.push_back(0); rvd_log.push_back(p0_rdata_o); end
    if (p1_rvalid_o) begin rv_log.push_back(1); rvd_log.push_back(p1_rdata_o); end

    if (rv && m_q.size() == 0) m_err = 1'b1;
    if (eacc) void'(m_q.pop_front());
    if (egnt) begin
      m_q.push_back(sel);
      m_last = (sel == 1);
      pend[sel] = 1'b0;
    end
    m_hold = ereq && !g;
    m_hold_port = sel;
    @(negedge clk);
  endtask

  // Assert reset between clock edges with requests and responses active; outputs must clear at once.
  task automatic do_reset();
    logic [31:0] rd;
    rd = $urandom;
    drive_ports();
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = rd;
    rst = 1'b1;
    #1;
    check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
    check_eq("rst_p0_gnt", 32'(p0_gnt_o), 32'd0);
    check_eq("rst_p1_gnt", 32'(p1_gnt_o), 32'd0);
    check_eq("rst_p0_rvalid", 32'(p0_rvalid_o), 32'd0);
    check_eq("rst_p1_rvalid", 32'(p1_rvalid_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_p0_rdata", p0_rdata_o, rd);
    check_eq("rst_p1_rdata", p1_rdata_o, rd);
    m_q.delete();
    m_last = 1'b1;
    m_hold = 1'b0;
    m_hold_port = 0;
    m_err = 1'b0;
    @(negedge clk);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; r_addr[p] = '0; r_we[p] = 1'b0; r_be[p] = '0; r_wdata[p] = '0;
    end
    m_last = 1'b1; m_hold = 1'b0; m_hold_port = 0; m_err = 1'b0;
    @(negedge clk);
    do_reset();

    // Both ports contend with continuous grant and one-cycle responses: strict alternation.
    clear_reqs();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) new_req(0, 32'h1000 + 32'(k) * 4);
      if (!pend[1]) new_req(1, 32'h2000 + 32'(k) * 4);
      step(1'b1, k > 0, 32'hC0DE_0000 + 32'(k));
    end
    step(1'b0, 1'b1, 32'hC0DE_0004);
    check_eq("alt_gnt_count", 32'(gnt_log.size()), 32'd4);
    check_eq("alt_rv_count", 32'(rv_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) check_eq("alt_gnt_port", 32'(gnt_log[i]), 32'(i % 2));
      if (i < rv_log.size()) begin
        check_eq("alt_rv_port", 32'(rv_log[i]), 32'(i % 2));
        check_eq("alt_rv_data", rvd_log[i], 32'hC0DE_0001 + 32'(i));
      end
    end

    // Memory stalls the grant: the held port 1 keeps the bus while port 0 waits.
    clear_reqs();
    do_reset();
    new_req(1, 32'h0000_2000);
    step(1'b0, 1'b0, 32'h0);
    new_req(0, 32'h0000_1000);
    step(1'b0, 1'b0, 32'h0);
    check_eq("hold_addr_c2", obs_addr, 32'h0000_2000);
    step(1'b0, 1'b0, 32'h0);
    check_eq("hold_addr_c3", obs_addr, 32'h0000_2000);
    step(1'b1, 1'b0, 32'h0);
    check_eq("hold_p1_gnt_c4", 32'(obs_p1_gnt), 32'd1);
    check_eq("hold_p0_gnt_c4", 32'(obs_p0_gnt), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    check_eq("hold_p0_gnt_c5", 32'(obs_p0_gnt), 32'd1);

    // Outstanding limit: third request blocked; a response frees a slot in the same cycle.
    clear_reqs();
    do_reset();
    new_req(0, 32'h10); step(1'b1, 1'b0, 32'h0);
    new_req(1, 32'h20); step(1'b1, 1'b0, 32'h0);
    new_req(0, 32'h30); step(1'b1, 1'b0, 32'h0);
    check_eq("lim_req_blocked", 32'(obs_req), 32'd0);
    step(1'b1, 1'b1, 32'h55);
    check_eq("lim_gnt_with_rv", 32'(obs_p0_gnt), 32'd1);
    new_req(1, 32'h40); step(1'b1, 1'b0, 32'h0);
    check_eq("lim_still_full", 32'(obs_req), 32'd0);
    check_eq("lim_busy", 32'(obs_busy), 32'd1);

    // Response routing in grant order.
    clear_reqs();
    do_reset();
    new_req(0, 32'h100); step(1'b1, 1'b0, 32'h0);
    new_req(1, 32'h200); step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hAAAA);
    check_eq("route_p0_rv", 32'(obs_p0_rv), 32'd1);
    check_eq("route_p1_rv_a", 32'(obs_p1_rv), 32'd0);
    check_eq("route_p0_data", obs_p0_rdata, 32'hAAAA);
    step(1'b0, 1'b1, 32'hBBBB);
    check_eq("route_p1_rv", 32'(obs_p1_rv), 32'd1);
    check_eq("route_p0_rv_b", 32'(obs_p0_rv), 32'd0);
    check_eq("route_p1_data", obs_p1_rdata, 32'hBBBB);

    // Spurious response: ignored, flags a sticky error until reset.
    clear_reqs();
    do_reset();
    step(1'b0, 1'b1, 32'h1234);
    check_eq("spur_p0_rv", 32'(obs_p0_rv), 32'd0);
    check_eq("spur_p1_rv", 32'(obs_p1_rv), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("spur_err_set", 32'(obs_err), 32'd1);
    check_eq("spur_busy", 32'(obs_busy), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    check_eq("spur_err_sticky", 32'(obs_err), 32'd1);
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    check_eq("spur_err_cleared", 32'(obs_err), 32'd0);

    // Reset with two outstanding: outputs drop at once, first tie afterwards goes to port 0.
    clear_reqs();
    do_reset();
    new_req(0, 32'h500); step(1'b1, 1'b0, 32'h0);
    new_req(1, 32'h600); step(1'b1, 1'b0, 32'h0);
    new_req(0, 32'h700); new_req(1, 32'h800);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    check_eq("post_rst_tie_p0", 32'(obs_p0_gnt), 32'd1);
    step(1'b0, 1'b1, 32'h9);
    check_eq("post_rst_rv_p0", 32'(obs_p0_rv), 32'd1);

    // Random traffic; the second half also injects spurious responses.
    clear_reqs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit g, rv;
      if ($urandom_range(0, 399) == 0) do_reset();
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) new_req(p, $urandom);
      g = ($urandom_range(0, 3) != 0);
      if (m_q.size() > 0) rv = ($urandom_range(0, 4) < 2);
      else rv = (c >= 1500) && ($urandom_range(0, 39) == 0);
      step(g, rv, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_data_arbiter.md
CV32E40P_DATA_ARBITER -- requirements
Module: cv32e40p_data_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered memory transactions (legal 1..3).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports p0_req_i  input  1, p0_addr_i  input  32, p0_we_i  input  1, p0_be_i  input  4, p0_wdata_i  input  32  for port 0 (LSU) request.
REQ-005 SHALL have ports p0_gnt_o  output  1, p0_rvalid_o  output  1, p0_rdata_o  output  32  for port 0 grant and response.
REQ-006 SHALL have ports p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i (inputs) and p1_gnt_o, p1_rvalid_o, p1_rdata_o (outputs) for port 1 (debug/DMA), with the same widths as port 0.
REQ-007 SHALL have ports mem_req_o  output  1, mem_addr_o  output  32, mem_we_o  output  1, mem_be_o  output  4, mem_wdata_o  output  32  for the data-memory request.
REQ-008 SHALL have ports mem_gnt_i  input  1, mem_rvalid_i  input  1, mem_rdata_i  input  32  for the data-memory grant and response.
REQ-009 SHALL have port busy_o  output  1  high while any transaction is outstanding.
REQ-010 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-011 SHALL keep an outstanding counter cnt_q: +1 on mem_req_o&mem_gnt_i, -1 on accepted mem_rvalid_i, unchanged on both or neither.
REQ-012 SHALL set can_issue = (cnt_q < MAX_OUTSTANDING) | mem_rvalid_i; SHALL drive mem_req_o = can_issue & (selected port req).
REQ-013 SHALL use FSM ARB (no pending request) / HOLD (mem_req_o high, mem_gnt_i low).
REQ-014 In ARB, SHALL select round-robin: one requester wins; both -> port not granted last (last_q, reset value port 1, so port 0 wins first tie).
REQ-015 ARB -> HOLD when mem_req_o & ~mem_gnt_i, latching the selected port in sel_q; SHALL stay in HOLD, keep sel_q and ignore the other port until mem_gnt_i, then return to ARB.
REQ-016 SHALL mux mem_addr_o/we/be/wdata from the selected port combinationally; values SHALL equal that port's inputs, which the requester holds stable until its gnt.
REQ-017 SHALL assert pX_gnt_o = mem_gnt_i & mem_req_o & (selected == X), same cycle, never for both ports.
REQ-018 SHALL push the granted port ID into an ID FIFO (depth MAX_OUTSTANDING) on every grant and pop on every accepted mem_rvalid_i; push and pop in one cycle SHALL both take effect.
REQ-019 SHALL assert pX_rvalid_o = mem_rvalid_i & (FIFO head == X) & (cnt_q != 0) in the same cycle; rdata SHALL be mem_rdata_i broadcast to both ports.
REQ-020 Responses SHALL return in grant order; no reordering.
REQ-021 mem_rvalid_i with cnt_q == 0 SHALL be ignored (no pop, no pXrvalid, counter unchanged) and SHALL set err_o until reset.
REQ-022 SHALL update last_q on every grant.
REQ-023 When cnt_q == MAX_OUTSTANDING with no rvalid, mem_req_o SHALL be 0 and FSM SHALL stay in ARB (no HOLD without request).
REQ-024 busy_o = (cnt_q != 0); combinational request-to-grant latency 0 cycles; response latency set by memory.
REQ-025 A requester dropping req while in HOLD is illegal; behaviour unspecified, not checked.

Reset
REQ-026 On rst high, asynchronously: cnt_q=0, FIFO empty, FSM=ARB, last_q=port 1, err_o=0.
REQ-027 During reset all *_gnt_o, *_rvalid_o, mem_req_o, busy_o SHALL be 0; rdata outputs follow mem_rdata_i.
REQ-028 Reset mid-transaction SHALL discard outstanding IDs; post-reset rvalid SHALL be treated per REQ-021.

Verification
REQ-029 Both ports request, mem_gnt_i=1 continuously, 1-cycle rvalid -> grants alternate p0,p1,p0,p1; each rvalid routed to matching port.
REQ-030 p1 requests, mem_gnt_i low 3 cycles, p0 requests in cycle 2 -> FSM HOLD, mem_addr_o stays p1_addr_i, p1_gnt_o on cycle 4, then p0 granted.
REQ-031 MAX_OUTSTANDING=2, two grants, no rvalid -> mem_req_o=0 on third request; rvalid plus new grant same cycle -> cnt_q stays 2.
REQ-032 p0 granted at 0x100, p1 at 0x200, rdata 0xAAAA then 0xBBBB -> p0_rdata/rvalid gets 0xAAAA, p1 gets 0xBBBB.
REQ-033 mem_rvalid_i with no outstanding -> err_o=1, no pX_rvalid_o, cnt_q=0; err_o clears only on rst.
REQ-034 rst asserted with cnt_q=2 -> all outputs 0 immediately; after release first tie granted to p0.
